// File: rtl/seg7_pkg.sv
// Shared constants for the seg7_hex display driver: segment ordering,
// the all-off pattern and the active-low hex glyph table.
package seg7_pkg;

    localparam int unsigned NIB_W = 4;
    localparam int unsigned SEG_W = 7;

    // Segment bit positions inside one digit (bit0 = a ... bit6 = g).
    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    // Active-low: a 1 turns the segment off.
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

    localparam logic [SEG_W-1:0] GLYPH_0 = 7'h40;
    localparam logic [SEG_W-1:0] GLYPH_1 = 7'h79;
    localparam logic [SEG_W-1:0] GLYPH_2 = 7'h24;
    localparam logic [SEG_W-1:0] GLYPH_3 = 7'h30;
    localparam logic [SEG_W-1:0] GLYPH_4 = 7'h19;
    localparam logic [SEG_W-1:0] GLYPH_5 = 7'h12;
    localparam logic [SEG_W-1:0] GLYPH_6 = 7'h02;
    localparam logic [SEG_W-1:0] GLYPH_7 = 7'h78;
    localparam logic [SEG_W-1:0] GLYPH_8 = 7'h00;
    localparam logic [SEG_W-1:0] GLYPH_9 = 7'h10;
    localparam logic [SEG_W-1:0] GLYPH_A = 7'h08;
    localparam logic [SEG_W-1:0] GLYPH_B = 7'h03;
    localparam logic [SEG_W-1:0] GLYPH_C = 7'h46;
    localparam logic [SEG_W-1:0] GLYPH_D = 7'h21;
    localparam logic [SEG_W-1:0] GLYPH_E = 7'h06;
    localparam logic [SEG_W-1:0] GLYPH_F = 7'h0E;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [SEG_W-1:0] seg_c
);

    // Table lookup of the glyph for one nibble.
    always_comb begin
        seg_c = SEG_OFF;
        case (nibble)
            4'h0: seg_c = GLYPH_0;
            4'h1: seg_c = GLYPH_1;
            4'h2: seg_c = GLYPH_2;
            4'h3: seg_c = GLYPH_3;
            4'h4: seg_c = GLYPH_4;
            4'h5: seg_c = GLYPH_5;
            4'h6: seg_c = GLYPH_6;
            4'h7: seg_c = GLYPH_7;
            4'h8: seg_c = GLYPH_8;
            4'h9: seg_c = GLYPH_9;
            4'hA: seg_c = GLYPH_A;
            4'hB: seg_c = GLYPH_B;
            4'hC: seg_c = GLYPH_C;
            4'hD: seg_c = GLYPH_D;
            4'hE: seg_c = GLYPH_E;
            4'hF: seg_c = GLYPH_F;
            default: seg_c = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_hex.sv
// Multi-digit hex 7-segment driver with a shadow register committed at PWM
// frame boundaries, per-digit blank/blink masks and PWM brightness.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_hex
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS    = 6,
    parameter int unsigned PWM_BITS  = 4,
    parameter int unsigned BLINK_DIV = 12500000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      we,
    input  logic [NIB_W*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]         blank_mask,
    input  logic [DIGITS-1:0]         blink_mask,
    input  logic [PWM_BITS-1:0]       brightness,
    output logic [SEG_W*DIGITS-1:0]   hex,
    output logic                      pending
);

    localparam int unsigned DATA_W  = NIB_W * DIGITS;
    localparam int unsigned HEX_W   = SEG_W * DIGITS;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PWM_BITS-1:0] PWM_MAX    = '1;
    localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [PWM_BITS-1:0] pwm_cnt_q,     pwm_cnt_d;
    logic [BLINK_W-1:0]  blink_cnt_q,   blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [DATA_W-1:0]   shd_data_q,    shd_data_d;
    logic [DIGITS-1:0]   shd_blank_q,   shd_blank_d;
    logic [DIGITS-1:0]   shd_blink_q,   shd_blink_d;
    logic [DATA_W-1:0]   disp_data_q,   disp_data_d;
    logic [DIGITS-1:0]   disp_blank_q,  disp_blank_d;
    logic [DIGITS-1:0]   disp_blink_q,  disp_blink_d;
    logic                pending_q,     pending_d;
    logic [HEX_W-1:0]    hex_q,         hex_d;

    logic                frame_end_c;
    logic                pwm_on_c;
    logic [DIGITS-1:0]   lzb_c;
    logic [SEG_W-1:0]    glyph_c [DIGITS];

    // One decoder per digit, fed from the committed display register.
    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_dec
        seg7_decode u_dec (
            .nibble (disp_data_q[g*NIB_W +: NIB_W]),
            .seg_c  (glyph_c[g])
        );
    end

`ifdef SEG7_LZB_EN
    logic lzb_seen_c;

    // Blank zero nibbles above the most significant nonzero one; digit 0 stays.
    always_comb begin
        lzb_seen_c = 1'b0;
        lzb_c      = '0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            if (disp_data_q[i*NIB_W +: NIB_W] != '0) begin
                lzb_seen_c = 1'b1;
            end
            lzb_c[i] = ~lzb_seen_c;
        end
    end
`else
    assign lzb_c = '0;
`endif

    // Frame boundary and PWM gate; full-scale brightness is always on.
    always_comb begin
        frame_end_c = (pwm_cnt_q == PWM_MAX);
        pwm_on_c    = (brightness == PWM_MAX) || (pwm_cnt_q < brightness);
    end

    // Counters, shadow/display transfer and pending flag.
    always_comb begin
        pwm_cnt_d     = pwm_cnt_q + 1'b1;
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
        shd_data_d    = shd_data_q;
        shd_blank_d   = shd_blank_q;
        shd_blink_d   = shd_blink_q;
        disp_data_d   = disp_data_q;
        disp_blank_d  = disp_blank_q;
        disp_blink_d  = disp_blink_q;
        pending_d     = pending_q;

        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end

        // Commit takes the shadow as it was before any same-cycle write.
        if (frame_end_c) begin
            disp_data_d  = shd_data_q;
            disp_blank_d = shd_blank_q;
            disp_blink_d = shd_blink_q;
            pending_d    = 1'b0;
        end

        // A write always wins the pending flag and overwrites the shadow.
        if (we) begin
            shd_data_d  = data;
            shd_blank_d = blank_mask;
            shd_blink_d = blink_mask;
            pending_d   = 1'b1;
        end
    end

    // Per-digit output select: any off condition forces SEG_OFF.
    always_comb begin
        hex_d = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (disp_blank_q[i] || (disp_blink_q[i] && blink_phase_q) ||
                !pwm_on_c || lzb_c[i]) begin
                hex_d[i*SEG_W +: SEG_W] = SEG_OFF;
            end else begin
                hex_d[i*SEG_W +: SEG_W] = glyph_c[i];
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            shd_data_q    <= '0;
            shd_blank_q   <= '0;
            shd_blink_q   <= '0;
            disp_data_q   <= '0;
            disp_blank_q  <= '0;
            disp_blink_q  <= '0;
            pending_q     <= 1'b0;
            hex_q         <= '1;
        end else begin
            pwm_cnt_q     <= pwm_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            shd_data_q    <= shd_data_d;
            shd_blank_q   <= shd_blank_d;
            shd_blink_q   <= shd_blink_d;
            disp_data_q   <= disp_data_d;
            disp_blank_q  <= disp_blank_d;
            disp_blink_q  <= disp_blink_d;
            pending_q     <= pending_d;
            hex_q         <= hex_d;
        end
    end

    assign hex     = hex_q;
    assign pending = pending_q;

endmodule
